// File: rtl/param_beacon.sv
// param_beacon: streams a framed dump of its elaborated parameters; header registered one cycle after start.
// Words hold until accepted under backpressure; PARAM_BEACON_CKSUM_EN appends an XOR checksum word.
module param_beacon #(
  parameter int W      = 9,
  parameter int X      = 9,
  parameter int Y      = 9,
  parameter int Z      = 9,
  parameter int DATA_W = 32,
  parameter int ID     = 0,
  parameter int REPEAT = 0,
  parameter int GAP    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [7:0]        frame_cnt
);
  typedef logic [X-1:0] probe_x_t;
  typedef logic [Z-1:0] probe_z_t;
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

`ifdef PARAM_BEACON_CKSUM_EN
  localparam int NWORDS = 6;
`else
  localparam int NWORDS = 5;
`endif
  localparam logic [2:0]  LAST_IDX = 3'(NWORDS - 1);
  localparam logic [7:0]  Y8       = Y[7:0];
  localparam logic [63:0] HDR64    = {40'd0, 8'hA5, 8'(ID), 8'(NWORDS)};

  localparam logic [DATA_W-1:0] C_HDR = DATA_W'(HDR64);
  localparam logic [DATA_W-1:0] C_W   = DATA_W'(64'(W));
  localparam logic [DATA_W-1:0] C_X   = DATA_W'(64'($bits(probe_x_t)));
  localparam logic [DATA_W-1:0] C_Y   = DATA_W'(Y8);
  localparam logic [DATA_W-1:0] C_Z   = DATA_W'(64'($bits(probe_z_t)));
`ifdef PARAM_BEACON_CKSUM_EN
  // All words are elaboration constants, so the checksum folds to a constant too.
  localparam logic [DATA_W-1:0] C_SUM = C_HDR ^ C_W ^ C_X ^ C_Y ^ C_Z;
`endif

  function automatic logic [DATA_W-1:0] word_at(input logic [2:0] idx);
    case (idx)
      3'd0:    word_at = C_HDR;
      3'd1:    word_at = C_W;
      3'd2:    word_at = C_X;
      3'd3:    word_at = C_Y;
      3'd4:    word_at = C_Z;
`ifdef PARAM_BEACON_CKSUM_EN
      3'd5:    word_at = C_SUM;
`endif
      default: word_at = '0;
    endcase
  endfunction

  state_t            r_state;
  logic [2:0]        r_idx;
  logic [7:0]        r_gap_cnt;
  logic              r_abort_pend;
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic              r_last;
  logic              r_busy;
  logic [7:0]        r_frame_cnt;

  logic w_hs;
  logic w_abort;
  assign w_hs    = r_valid & out_ready;
  assign w_abort = abort | r_abort_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
      r_abort_pend <= 1'b0;
      r_valid      <= 1'b0;
      r_data       <= '0;
      r_last       <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_cnt  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_abort_pend <= 1'b0;
          if (start && !abort) begin
            r_state <= S_SEND;
            r_idx   <= 3'd0;
            r_valid <= 1'b1;
            r_data  <= word_at(3'd0);
            r_last  <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort) r_abort_pend <= 1'b1;
          if (w_hs) begin
            if (r_idx == LAST_IDX) begin
              r_frame_cnt <= r_frame_cnt + 8'd1;
              if (w_abort || REPEAT == 0) begin
                r_state      <= S_IDLE;
                r_valid      <= 1'b0;
                r_last       <= 1'b0;
                r_busy       <= 1'b0;
                r_abort_pend <= 1'b0;
              end else if (GAP == 0) begin
                r_idx  <= 3'd0;
                r_data <= word_at(3'd0);
                r_last <= 1'b0;
              end else begin
                r_state   <= S_GAP;
                r_valid   <= 1'b0;
                r_last    <= 1'b0;
                r_gap_cnt <= 8'd0;
              end
            end else if (w_abort) begin
              // Aborted frame: the accepted word was the last one sent, no count.
              r_state      <= S_IDLE;
              r_valid      <= 1'b0;
              r_last       <= 1'b0;
              r_busy       <= 1'b0;
              r_abort_pend <= 1'b0;
            end else begin
              r_idx  <= r_idx + 3'd1;
              r_data <= word_at(r_idx + 3'd1);
              r_last <= ((r_idx + 3'd1) == LAST_IDX);
            end
          end
        end
        S_GAP: begin
          if (w_abort) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_abort_pend <= 1'b0;
          end else if (r_gap_cnt == 8'(GAP - 1)) begin
            r_state <= S_SEND;
            r_idx   <= 3'd0;
            r_valid <= 1'b1;
            r_data  <= word_at(3'd0);
            r_last  <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign frame_cnt = r_frame_cnt;
endmodule
